cpu_run_ctrl: RTL and testbench

Synthesizable run controller for the multicycle MIPS CPU. It sequences the CPU's reset and loads a programmable boot PC onto `outside_pc`. While the CPU runs it counts cycles and captures every new `(now_pc, ins)` pair into a circular trace buffer. It stops the run on abort, on a cycle limit, or on a detected halt (PC unchanged for a window), and leaves the trace readable afterwards.

---
 rtl/cpu_run_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the multicycle MIPS CPU: boot sequencing, cycle limit,
// halt detection and a circular {pc, ins} trace buffer readable after the run.
module cpu_run_ctrl #(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned INS_W       = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned HALT_WINDOW = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic                      abort,
  input  logic [PC_W-1:0]           boot_pc,
  input  logic [31:0]               max_cycles,
  output logic                      cpu_rst,
  output logic [PC_W-1:0]           outside_pc,
  input  logic [PC_W-1:0]           now_pc,
  input  logic [INS_W-1:0]          ins,
  input  logic                      trace_rd_en,
  output logic [PC_W+INS_W-1:0]     trace_rd_data,
  output logic                      trace_rd_valid,
  output logic [$clog2(DEPTH):0]    trace_count,
  output logic                      trace_ovf,
  output logic [31:0]               cycle_cnt,
  output logic                      running,
  output logic                      done,
  output logic [1:0]                halt_reason
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned ENT_W  = PC_W + INS_W;
  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned STAB_W = $clog2(HALT_WINDOW + 1);

  localparam logic [1:0] RSN_NONE  = 2'b00;
  localparam logic [1:0] RSN_HALT  = 2'b01;
  localparam logic [1:0] RSN_LIMIT = 2'b10;
  localparam logic [1:0] RSN_ABORT = 2'b11;

  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

  state_t              state_q, state_n;
  logic [HOLD_W-1:0]   hold_q, hold_n;
  logic [31:0]         max_q, max_n;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_n;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_n;
  logic [PC_W-1:0]     prev_pc_q, prev_pc_n;
  logic [STAB_W-1:0]   stable_q, stable_n;
  logic [PC_W-1:0]     outside_pc_n;
  logic [31:0]         cycle_cnt_n;
  logic [CNT_W-1:0]    trace_count_n;
  logic                trace_ovf_n;
  logic [1:0]          halt_reason_n;
  logic [ENT_W-1:0]    rd_data_n;
  logic                rd_valid_n;
  logic                wr_en_c;
  logic                first_c;

  logic [ENT_W-1:0]    mem [DEPTH];

  // Next-state and next-output logic; every register holds unless changed below.
  always_comb begin
    state_n       = state_q;
    hold_n        = hold_q;
    max_n         = max_q;
    wr_ptr_n      = wr_ptr_q;
    rd_ptr_n      = rd_ptr_q;
    prev_pc_n     = prev_pc_q;
    stable_n      = stable_q;
    outside_pc_n  = outside_pc;
    cycle_cnt_n   = cycle_cnt;
    trace_count_n = trace_count;
    trace_ovf_n   = trace_ovf;
    halt_reason_n = halt_reason;
    rd_data_n     = trace_rd_data;
    rd_valid_n    = 1'b0;
    wr_en_c       = 1'b0;
    first_c       = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_n       = HOLD;
          hold_n        = '0;
          outside_pc_n  = boot_pc;
          max_n         = max_cycles;
          wr_ptr_n      = '0;
          rd_ptr_n      = '0;
          stable_n      = '0;
          trace_count_n = '0;
          trace_ovf_n   = 1'b0;
          cycle_cnt_n   = '0;
          halt_reason_n = RSN_NONE;
        end else if (trace_rd_en && (trace_count != '0)) begin
          rd_data_n     = mem[rd_ptr_q];
          rd_valid_n    = 1'b1;
          rd_ptr_n      = rd_ptr_q + PTR_W'(1);
          trace_count_n = trace_count - CNT_W'(1);
        end
      end
      HOLD: begin
        if (abort) begin
          state_n       = DONE;
          halt_reason_n = RSN_ABORT;
        end else if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_n = RUN;
        end else begin
          hold_n = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        cycle_cnt_n = cycle_cnt + 32'd1;
        prev_pc_n   = now_pc;
        first_c     = (cycle_cnt == '0);
        // A full buffer drops its oldest entry to make room.
        if (first_c || (now_pc != prev_pc_q)) begin
          wr_en_c  = 1'b1;
          wr_ptr_n = wr_ptr_q + PTR_W'(1);
          stable_n = '0;
          if (trace_count == CNT_W'(DEPTH)) begin
            rd_ptr_n    = rd_ptr_q + PTR_W'(1);
            trace_ovf_n = 1'b1;
          end else begin
            trace_count_n = trace_count + CNT_W'(1);
          end
        end else begin
          stable_n = stable_q + STAB_W'(1);
        end
        if (abort) begin
          state_n       = DONE;
          halt_reason_n = RSN_ABORT;
        end else if ((max_q != '0) && (cycle_cnt_n == max_q)) begin
          state_n       = DONE;
          halt_reason_n = RSN_LIMIT;
        end else if (stable_n == STAB_W'(HALT_WINDOW)) begin
          state_n       = DONE;
          halt_reason_n = RSN_HALT;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      hold_q         <= '0;
      max_q          <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      prev_pc_q      <= '0;
      stable_q       <= '0;
      outside_pc     <= '0;
      cycle_cnt      <= '0;
      trace_count    <= '0;
      trace_ovf      <= 1'b0;
      halt_reason    <= RSN_NONE;
      trace_rd_data  <= '0;
      trace_rd_valid <= 1'b0;
      cpu_rst        <= 1'b1;
      running        <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_n;
      hold_q         <= hold_n;
      max_q          <= max_n;
      wr_ptr_q       <= wr_ptr_n;
      rd_ptr_q       <= rd_ptr_n;
      prev_pc_q      <= prev_pc_n;
      stable_q       <= stable_n;
      outside_pc     <= outside_pc_n;
      cycle_cnt      <= cycle_cnt_n;
      trace_count    <= trace_count_n;
      trace_ovf      <= trace_ovf_n;
      halt_reason    <= halt_reason_n;
      trace_rd_data  <= rd_data_n;
      trace_rd_valid <= rd_valid_n;
      cpu_rst        <= (state_n != RUN);
      running        <= (state_n == RUN);
      done           <= (state_n == DONE);
    end
  end

  // Trace storage; contents are qualified by the pointers, so no reset needed.
  always_ff @(posedge CLK) begin
    if (wr_en_c) mem[wr_ptr_q] <= {now_pc, ins};
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed self-checking bench for cpu_run_ctrl: boot, halt, cycle limit,
// trace overflow/readback, abort priority, dropped reads and async reset.
module tb_cpu_run_ctrl;

  logic        CLK;
  logic        RST;
  logic        start;
  logic        abort;
  logic [31:0] boot_pc;
  logic [31:0] max_cycles;
  logic        cpu_rst;
  logic [31:0] outside_pc;
  logic [31:0] now_pc;
  logic [31:0] ins;
  logic        trace_rd_en;
  logic [63:0] trace_rd_data;
  logic        trace_rd_valid;
  logic [4:0]  trace_count;
  logic        trace_ovf;
  logic [31:0] cycle_cnt;
  logic        running;
  logic        done;
  logic [1:0]  halt_reason;

  int total = 0;
  int bad   = 0;

  cpu_run_ctrl dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort),
    .boot_pc(boot_pc), .max_cycles(max_cycles),
    .cpu_rst(cpu_rst), .outside_pc(outside_pc),
    .now_pc(now_pc), .ins(ins),
    .trace_rd_en(trace_rd_en), .trace_rd_data(trace_rd_data),
    .trace_rd_valid(trace_rd_valid), .trace_count(trace_count),
    .trace_ovf(trace_ovf), .cycle_cnt(cycle_cnt),
    .running(running), .done(done), .halt_reason(halt_reason)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1);
  end

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return {16'hC0DE, pc[15:0]};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pc(input logic [31:0] pc);
    now_pc = pc;
    ins    = ins_of(pc);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b0; start = 1'b0; abort = 1'b0; boot_pc = '0; max_cycles = '0;
    now_pc = '0; ins = '0; trace_rd_en = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_cpu_rst",  64'(cpu_rst), 64'h1);
    check("rst_opc",      64'(outside_pc), 64'h0);
    check("rst_cyc",      64'(cycle_cnt), 64'h0);
    check("rst_count",    64'(trace_count), 64'h0);
    check("rst_rdata",    trace_rd_data, 64'h0);
    check("rst_flags",    64'({trace_rd_valid, trace_ovf, running, done}), 64'h0);
    check("rst_reason",   64'(halt_reason), 64'h0);
    RST = 1'b1;
    tick();

    // Basic start, then halt on jump-to-self at 0x1C
    boot_pc = 32'h4; max_cycles = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("boot_opc_e0",  64'(outside_pc), 64'h4);
    check("boot_rst_e0",  64'(cpu_rst), 64'h1);
    tick();
    check("boot_rst_e1",  64'(cpu_rst), 64'h1);
    tick();
    check("boot_rst_e2",  64'(cpu_rst), 64'h0);
    check("boot_run_e2",  64'(running), 64'h1);
    check("boot_cyc_e2",  64'(cycle_cnt), 64'h0);
    for (int r = 1; r <= 11; r++) begin
      set_pc((r == 1) ? 32'h4 : (r == 2) ? 32'h8 : 32'h1C);
      tick();
      if (r == 1) begin
        check("run_cyc_first",   64'(cycle_cnt), 64'h1);
        check("run_count_first", 64'(trace_count), 64'h1);
      end
      if (r == 10) check("halt_not_early", 64'(running), 64'h1);
    end
    check("halt_done",    64'(done), 64'h1);
    check("halt_reason",  64'(halt_reason), 64'h1);
    check("halt_cpu_rst", 64'(cpu_rst), 64'h1);
    check("halt_cyc",     64'(cycle_cnt), 64'd11);
    check("halt_count",   64'(trace_count), 64'h3);

    // Back-to-back pops, then a pop on an empty buffer
    trace_rd_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] pc;
      pc = (i == 0) ? 32'h4 : (i == 1) ? 32'h8 : 32'h1C;
      tick();
      check("halt_pop_valid", 64'(trace_rd_valid), 64'h1);
      check("halt_pop_data",  trace_rd_data, {pc, ins_of(pc)});
    end
    tick();
    check("empty_pop_valid", 64'(trace_rd_valid), 64'h0);
    trace_rd_en = 1'b0;
    check("empty_count", 64'(trace_count), 64'h0);

    // Cycle limit 20 with PC changing every 4 cycles; read attempt during RUN
    boot_pc = 32'h100; max_cycles = 32'd20; start = 1'b1;
    tick();
    start = 1'b0;
    check("lim_opc",    64'(outside_pc), 64'h100);
    check("lim_clear",  64'({done, trace_ovf, halt_reason}), 64'h0);
    check("lim_cnt0",   64'(trace_count), 64'h0);
    tick(); tick();
    for (int r = 1; r <= 20; r++) begin
      set_pc(32'h100 + 32'(4 * ((r - 1) / 4)));
      trace_rd_en = (r == 10);
      tick();
      if (r == 10) begin
        check("run_read_valid", 64'(trace_rd_valid), 64'h0);
        check("run_read_count", 64'(trace_count), 64'h3);
      end
      if (r == 19) check("lim_not_early", 64'(running), 64'h1);
    end
    trace_rd_en = 1'b0;
    check("lim_done",   64'(done), 64'h1);
    check("lim_reason", 64'(halt_reason), 64'h2);
    check("lim_cyc",    64'(cycle_cnt), 64'd20);
    check("lim_count",  64'(trace_count), 64'h5);
    tick(); tick();
    check("lim_cyc_hold", 64'(cycle_cnt), 64'd20);

    // Overflow: 20 distinct PCs into a 16-entry buffer, stopped by abort
    boot_pc = 32'h0; max_cycles = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int r = 1; r <= 20; r++) begin
      set_pc(32'(4 * (r - 1)));
      tick();
      if (r == 16) check("ovf_at16", 64'({trace_ovf, trace_count}), 64'h10);
      if (r == 17) check("ovf_at17", 64'({trace_ovf, trace_count}), 64'h30);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ovf_done",   64'(done), 64'h1);
    check("ovf_reason", 64'(halt_reason), 64'h3);
    check("ovf_flag",   64'(trace_ovf), 64'h1);
    check("ovf_count",  64'(trace_count), 64'd16);
    trace_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] pc;
      pc = 32'h10 + 32'(4 * i);
      tick();
      check("ovf_pop_valid", 64'(trace_rd_valid), 64'h1);
      check("ovf_pop_data",  trace_rd_data, {pc, ins_of(pc)});
    end
    tick();
    check("ovf_pop17_valid", 64'(trace_rd_valid), 64'h0);
    trace_rd_en = 1'b0;

    // Abort on the same edge the cycle limit is reached
    boot_pc = 32'h200; max_cycles = 32'd5; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int r = 1; r <= 5; r++) begin
      set_pc(32'h200 + 32'(4 * (r - 1)));
      abort = (r == 5);
      tick();
    end
    abort = 1'b0;
    check("prio_done",    64'(done), 64'h1);
    check("prio_reason",  64'(halt_reason), 64'h3);
    check("prio_cpu_rst", 64'(cpu_rst), 64'h1);

    // start and read together in DONE: start wins; then abort during HOLD
    boot_pc = 32'h300; max_cycles = 32'd0; start = 1'b1; trace_rd_en = 1'b1;
    tick();
    start = 1'b0; trace_rd_en = 1'b0;
    check("sr_valid",  64'(trace_rd_valid), 64'h0);
    check("sr_count",  64'(trace_count), 64'h0);
    check("sr_opc",    64'(outside_pc), 64'h300);
    check("sr_hold",   64'({done, running, cpu_rst}), 64'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("hold_abort_done",   64'({done, running, cpu_rst}), 64'h5);
    check("hold_abort_reason", 64'(halt_reason), 64'h3);
    check("hold_abort_cyc",    64'(cycle_cnt), 64'h0);

    // Asynchronous reset in the middle of a run
    boot_pc = 32'h400; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    for (int r = 1; r <= 3; r++) begin
      set_pc(32'h400 + 32'(4 * r));
      tick();
    end
    check("mid_running", 64'(running), 64'h1);
    check("mid_count",   64'(trace_count), 64'h3);
    #3;
    RST = 1'b0;
    #1;
    check("arst_cpu_rst", 64'(cpu_rst), 64'h1);
    check("arst_flags",   64'({running, done, trace_ovf, trace_rd_valid}), 64'h0);
    check("arst_opc",     64'(outside_pc), 64'h0);
    check("arst_cyc",     64'(cycle_cnt), 64'h0);
    check("arst_count",   64'(trace_count), 64'h0);
    check("arst_reason",  64'(halt_reason), 64'h0);
    RST = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
